// File: rtl/mem_ctrl_pkg.sv
// Shared types and sizing for the UART byte-buffer controller.
package mem_ctrl_pkg;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    // Carriage return ends a line typed into the UART.
    localparam logic [DATA_W-1:0] TERM_BYTE = 8'h0D;

    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_PRESENT  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_ram_ctrl.sv
// Byte-buffer sequencer: stores UART rx bytes in a 64x8 RAM, then plays them
// back in order over a valid/ready port. Owns all RAM addressing.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   ST_LOAD     | accepting rx bytes, writing them at address = count
//   ST_RD_ISSUE | ram_addr = rd_ptr is on the RAM port (read issued)
//   ST_RD_WAIT  | ram_rdata valid, captured into out_data
//   ST_PRESENT  | out_valid high, waiting for out_ready
module mem_ram_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int                DEPTH     = mem_ctrl_pkg::DEPTH,
    parameter int                ADDR_W    = mem_ctrl_pkg::ADDR_W,
    parameter int                DATA_W    = mem_ctrl_pkg::DATA_W,
    parameter int                TERM_EN   = 1,
    parameter logic [DATA_W-1:0] TERM_BYTE = mem_ctrl_pkg::TERM_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              play_start,
    input  logic              clear,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              overflow,
    output logic              done
);

    localparam int               CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t state_q, state_d;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  rd_ptr_nxt;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              ram_we_q, ram_we_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              full_q, full_d;

    logic rx_term;
    logic buf_full;
    logic buf_empty;
    logic load_wr;
    logic play_req;
    logic xfer;
    logic last_byte;

    assign rx_term    = (TERM_EN != 0) && (rx_data == TERM_BYTE);
    assign buf_full   = (count_q == DEPTH_C);
    assign buf_empty  = (count_q == '0);
    assign load_wr    = (state_q == ST_LOAD) && rx_valid && !rx_term && !buf_full;
    // A byte arriving together with play_start is written first and is
    // part of the playback, so it also makes an empty buffer playable.
    assign play_req   = (state_q == ST_LOAD) &&
                        ((play_start && (!buf_empty || load_wr)) ||
                         (rx_valid && rx_term && !buf_empty));
    assign xfer       = (state_q == ST_PRESENT) && out_ready;
    assign last_byte  = (rd_ptr_q == count_q - CNT_W'(1));
    assign rd_ptr_nxt = rd_ptr_q + CNT_W'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; clear overrides everything.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (play_req) begin
                        state_d = ST_RD_ISSUE;
                    end
                end
                ST_RD_ISSUE: begin
                    // The RAM port was busy with the final write this cycle,
                    // so the read address goes out one cycle later.
                    if (!ram_we_q) begin
                        state_d = ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    state_d = ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (xfer) begin
                        state_d = last_byte ? ST_LOAD : ST_RD_ISSUE;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    // Output and datapath next values: counters, RAM port, playback port.
    always_comb begin
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;

        if (clear) begin
            count_d     = '0;
            rd_ptr_d    = '0;
            ram_addr_d  = '0;
            out_valid_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            // Drop a byte when not loading, or when the buffer is full and
            // the byte is data (a terminator at full just starts playback).
            if (rx_valid && ((state_q != ST_LOAD) || (!rx_term && buf_full))) begin
                overflow_d = 1'b1;
            end

            case (state_q)
                ST_LOAD: begin
                    if (load_wr) begin
                        ram_we_d    = 1'b1;
                        ram_addr_d  = count_q[ADDR_W-1:0];
                        ram_wdata_d = rx_data;
                        count_d     = count_q + CNT_W'(1);
                    end else if (play_req) begin
                        ram_addr_d = rd_ptr_q[ADDR_W-1:0];
                    end
                end
                ST_RD_ISSUE: begin
                    if (ram_we_q) begin
                        ram_addr_d = rd_ptr_q[ADDR_W-1:0];
                    end
                end
                ST_RD_WAIT: begin
                    out_data_d  = ram_rdata;
                    out_valid_d = 1'b1;
                end
                ST_PRESENT: begin
                    if (xfer) begin
                        out_valid_d = 1'b0;
                        if (last_byte) begin
                            done_d   = 1'b1;
                            count_d  = '0;
                            rd_ptr_d = '0;
                        end else begin
                            rd_ptr_d   = rd_ptr_nxt;
                            ram_addr_d = rd_ptr_nxt[ADDR_W-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d = (state_d != ST_LOAD);
        full_d = (count_d == DEPTH_C);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            full_q      <= full_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign full      = full_q;
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mem_ram_ctrl.sv
// Self-checking bench for mem_ram_ctrl with a behavioural byte-queue model.
module tb_mem_ram_ctrl;

    localparam logic [7:0] TERM = 8'h0D;

    logic       clk = 1'b0;
    logic       reset, rx_valid, play_start, clear, out_ready;
    logic [7:0] rx_data;
    logic       out_valid, ram_we, busy, full, overflow, done;
    logic [7:0] out_data, ram_wdata, ram_rdata;
    logic [5:0] ram_addr;
    logic [6:0] count;

    mem_ram_ctrl dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .play_start(play_start), .clear(clear), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .count(count), .busy(busy), .full(full), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM, read data one cycle after the address.
    logic [7:0] mem [64];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: bytes the buffer should hold, and the sticky drop flag.
    logic [7:0] exp_q[$];
    bit         exp_ovf = 1'b0;

    // Monitor state.
    int         wr_cnt = 0, done_cnt = 0, last_hs = 0, first_rise = 0;
    bit         hs_seen = 1'b0;
    logic       pv_valid = 1'b0, pv_hs = 1'b0, pv_clr = 1'b1;
    logic [7:0] pv_data = 8'h00;
    logic [7:0] out_log[$];

    // Observe the playback port and RAM port mid-cycle.
    always @(negedge clk) begin
        if (ram_we) wr_cnt++;
        if (done) done_cnt++;
        if (pv_valid && !pv_hs && !pv_clr) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, pv_data);
        end
        if (out_valid && !pv_valid) begin
            if (hs_seen) check("lat_next", cyc - last_hs, 3);
            else first_rise = cyc;
        end
        if (out_valid && out_ready) begin
            out_log.push_back(out_data);
            last_hs = cyc;
            hs_seen = 1'b1;
        end
        if (done || clear || reset) hs_seen = 1'b0;
        pv_valid = out_valid;
        pv_hs    = out_valid && out_ready;
        pv_data  = out_data;
        pv_clr   = clear || reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        do b = 8'($urandom); while (b == TERM);
        return b;
    endfunction

    // One rx strobe (optionally with play_start), checked one cycle later.
    task automatic send_byte(input logic [7:0] b, input bit ps, output bit started);
        bit store, term;
        term  = (b == TERM);
        store = !term && (exp_q.size() < 64);
        tick();
        rx_valid = 1'b1; rx_data = b; play_start = ps;
        tick();
        rx_valid = 1'b0; play_start = 1'b0;
        @(negedge clk);
        check("wr_en", ram_we, store);
        if (store) begin
            check("wr_addr", ram_addr, exp_q.size());
            check("wr_data", ram_wdata, b);
            exp_q.push_back(b);
        end else if (!term) begin
            exp_ovf = 1'b1;
        end
        check("count", count, exp_q.size());
        check("full", full, exp_q.size() == 64);
        check("ovf", overflow, exp_ovf);
        started = (exp_q.size() > 0) && (term || ps);
        check("busy", busy, started);
    endtask

    task automatic start_play(output int n);
        tick();
        play_start = 1'b1;
        n = cyc;
        tick();
        play_start = 1'b0;
    endtask

    // Drain playback with random backpressure and compare against the model.
    task automatic run_playback(input int pct);
        logic [7:0] exp[$];
        int d0;
        bit got;
        exp = exp_q;
        d0  = done_cnt;
        got = 1'b0;
        out_log.delete();
        for (int i = 0; i < 3000 && !got; i++) begin
            tick();
            out_ready = ($urandom_range(0, 99) < pct);
            if (done_cnt != d0) got = 1'b1;
        end
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        check("pb_done", got, 1);
        check("pb_pulses", done_cnt - d0, 1);
        check("pb_len", out_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < out_log.size(); i++)
            check($sformatf("pb_byte%0d", i), out_log[i], exp[i]);
        check("pb_count", count, 0);
        check("pb_busy", busy, 0);
        check("pb_ovf", overflow, exp_ovf);
        exp_q.delete();
    endtask

    task automatic do_clear(input string tag);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_we"}, ram_we, 0);
        exp_q.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        check("wait_valid", ok, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        bit s;
        int n, k, w0;
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        play_start = 1'b0; clear = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);

        // Fill and play with exact first-byte latency.
        send_byte(8'h41, 0, s);
        send_byte(8'h42, 0, s);
        send_byte(8'h43, 0, s);
        start_play(n);
        run_playback(100);
        check("lat_first", first_rise - n, 3);

        // Terminator auto-starts playback and is not stored.
        send_byte(8'h31, 0, s);
        send_byte(8'h32, 0, s);
        send_byte(TERM, 0, s);
        check("term_start", s, 1);
        run_playback(100);

        // play_start and terminator on an empty buffer are ignored.
        start_play(n);
        tick();
        @(negedge clk);
        check("empty_ps_busy", busy, 0);
        check("empty_ps_valid", out_valid, 0);
        send_byte(TERM, 0, s);

        // Byte together with play_start: written and played back.
        send_byte(rand_byte(), 1, s);
        run_playback(70);
        send_byte(rand_byte(), 0, s);
        send_byte(rand_byte(), 0, s);
        send_byte(rand_byte(), 1, s);
        run_playback(60);

        // Fill to 64, then one dropped byte.
        for (int i = 0; i < 65; i++) send_byte(rand_byte(), 0, s);
        start_play(n);
        run_playback(50);
        do_clear("clr0");

        // Backpressure window with an rx byte arriving during playback.
        for (int i = 0; i < 5; i++) send_byte(rand_byte(), 0, s);
        start_play(n);
        wait_valid();
        w0 = wr_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            out_ready = 1'b0;
            rx_valid  = (i == 3);
            rx_data   = rand_byte();
        end
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        check("bp_nowrite", wr_cnt - w0, 0);
        check("bp_ovf", overflow, 1);
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, exp_q[0]);
        exp_ovf = 1'b1;
        run_playback(100);
        do_clear("clr1");

        // Clear on the second PRESENT cycle.
        for (int i = 0; i < 3; i++) send_byte(rand_byte(), 0, s);
        start_play(n);
        tick();
        rx_valid = 1'b1;
        rx_data  = rand_byte();
        tick();
        rx_valid = 1'b0;
        wait_valid();
        check("mid_ovf_set", overflow, 1);
        do_clear("mid");
        send_byte(8'h5A, 0, s);
        start_play(n);
        run_playback(100);

        // Reset during playback behaves like clear.
        send_byte(rand_byte(), 0, s);
        send_byte(rand_byte(), 0, s);
        start_play(n);
        wait_valid();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mrst_valid", out_valid, 0);
        check("mrst_count", count, 0);
        check("mrst_busy", busy, 0);
        exp_q.delete();
        exp_ovf = 1'b0;
        send_byte(rand_byte(), 0, s);
        start_play(n);
        run_playback(80);

        // Randomized rounds.
        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(1, 70);
            for (int i = 0; i < k; i++) begin
                send_byte(rand_byte(), 0, s);
                repeat ($urandom_range(0, 2)) tick();
            end
            if ($urandom_range(0, 1) == 1) send_byte(TERM, 0, s);
            else start_play(n);
            run_playback($urandom_range(30, 100));
            do_clear("rclr");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
